// File: rtl/emg_scan_controller.sv
// emg_scan_controller: sequences an analog mux and ADC over Num_Channels EMG
// channels. Each channel gets a mux settling period, a one-cycle conversion
// request and a bounded wait for the ADC. Results come out as one-cycle sample
// pulses, and a frame-done pulse follows the last channel.
//
// Ports:
//   Clk, Reset    - system clock (rising edge), async active-high reset
//   Start         - level; begins a frame when sampled in IDLE
//   Continuous    - at frame end, 1 restarts at channel 0 without idling
//   Abort         - synchronous abort of the running frame
//   Adc_Done      - conversion-complete strobe, Adc_Data valid with it
//   Ch_Sel        - analog mux channel select
//   Adc_Start     - one-cycle conversion request
//   Sample_Valid  - one-cycle pulse; Sample_Data/Sample_Ch valid
//   Frame_Done    - one-cycle pulse after the last channel of a frame
//   Timeout_Err   - one-cycle pulse when a conversion is not answered
//   Busy          - high whenever the controller is not idle
module emg_scan_controller #(
    parameter int unsigned Num_Channels   = 16,
    parameter int unsigned Ch_Bits        = 4,
    parameter int unsigned Settle_Cycles  = 8,
    parameter int unsigned Timeout_Cycles = 255,
    parameter int unsigned Data_Bits      = 12
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Continuous,
    input  logic                 Abort,
    input  logic                 Adc_Done,
    input  logic [Data_Bits-1:0] Adc_Data,
    output logic [Ch_Bits-1:0]   Ch_Sel,
    output logic                 Adc_Start,
    output logic                 Sample_Valid,
    output logic [Data_Bits-1:0] Sample_Data,
    output logic [Ch_Bits-1:0]   Sample_Ch,
    output logic                 Frame_Done,
    output logic                 Timeout_Err,
    output logic                 Busy
);

    localparam int unsigned Cnt_Bits = 8;
    localparam logic [Ch_Bits-1:0]  Last_Ch      = Ch_Bits'(Num_Channels - 1);
    localparam logic [Cnt_Bits-1:0] Settle_Last  = Cnt_Bits'(Settle_Cycles - 1);
    localparam logic [Cnt_Bits-1:0] Timeout_Last = Cnt_Bits'(Timeout_Cycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONVERT,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t              state;
    logic [Cnt_Bits-1:0] settle_cnt;
    logic [Cnt_Bits-1:0] wait_cnt;

    // Scan sequencer; every output is a register updated alongside the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            wait_cnt     <= '0;
            Ch_Sel       <= '0;
            Adc_Start    <= 1'b0;
            Sample_Valid <= 1'b0;
            Sample_Data  <= '0;
            Sample_Ch    <= '0;
            Frame_Done   <= 1'b0;
            Timeout_Err  <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            // Pulse outputs are high for a single cycle only.
            Adc_Start    <= 1'b0;
            Sample_Valid <= 1'b0;
            Frame_Done   <= 1'b0;
            Timeout_Err  <= 1'b0;

            // Abort beats a same-cycle Adc_Done or timeout: nothing is reported.
            if ((state != IDLE) && Abort) begin
                state      <= IDLE;
                Ch_Sel     <= '0;
                settle_cnt <= '0;
                wait_cnt   <= '0;
                Busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            state      <= SETTLE;
                            Ch_Sel     <= '0;
                            settle_cnt <= '0;
                            Busy       <= 1'b1;
                        end
                    end

                    // Settle_Cycles cycles here; request conversion on leaving.
                    SETTLE: begin
                        if (settle_cnt >= Settle_Last) begin
                            state      <= CONVERT;
                            settle_cnt <= '0;
                            Adc_Start  <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + Cnt_Bits'(1);
                        end
                    end

                    CONVERT: begin
                        state    <= WAIT_DONE;
                        wait_cnt <= '0;
                    end

                    // Done on the final wait cycle still counts as a result.
                    WAIT_DONE: begin
                        if (Adc_Done) begin
                            state        <= NEXT;
                            Sample_Valid <= 1'b1;
                            Sample_Data  <= Adc_Data;
                            Sample_Ch    <= Ch_Sel;
                        end else if (wait_cnt >= Timeout_Last) begin
                            state       <= NEXT;
                            Timeout_Err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + Cnt_Bits'(1);
                        end
                    end

                    // Advance the channel, or close the frame on the last one.
                    NEXT: begin
                        settle_cnt <= '0;
                        if (Ch_Sel >= Last_Ch) begin
                            Frame_Done <= 1'b1;
                            if (Continuous) begin
                                state  <= SETTLE;
                                Ch_Sel <= '0;
                            end else begin
                                state <= IDLE;
                                Busy  <= 1'b0;
                            end
                        end else begin
                            state  <= SETTLE;
                            Ch_Sel <= Ch_Sel + Ch_Bits'(1);
                        end
                    end

                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_emg_scan_controller.sv
// tb_emg_scan_controller: checks emg_scan_controller against a timeline model.
// The model lays out each channel as settle / request / ADC wait / next using
// plain cycle arithmetic, and every DUT output is compared on every cycle.
module tb_emg_scan_controller;

    localparam int N    = 16;
    localparam int S    = 8;
    localparam int T    = 255;
    localparam int DW   = 12;
    localparam int CW   = 4;
    localparam int MAXC = 8192;
    localparam int MAXK = 64;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Continuous = 1'b0;
    logic          Abort = 1'b0;
    logic          Adc_Done = 1'b0;
    logic [DW-1:0] Adc_Data = '0;
    logic [CW-1:0] Ch_Sel;
    logic          Adc_Start;
    logic          Sample_Valid;
    logic [DW-1:0] Sample_Data;
    logic [CW-1:0] Sample_Ch;
    logic          Frame_Done;
    logic          Timeout_Err;
    logic          Busy;

    emg_scan_controller #(
        .Num_Channels  (N),
        .Ch_Bits       (CW),
        .Settle_Cycles (S),
        .Timeout_Cycles(T),
        .Data_Bits     (DW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Continuous  (Continuous),
        .Abort       (Abort),
        .Adc_Done    (Adc_Done),
        .Adc_Data    (Adc_Data),
        .Ch_Sel      (Ch_Sel),
        .Adc_Start   (Adc_Start),
        .Sample_Valid(Sample_Valid),
        .Sample_Data (Sample_Data),
        .Sample_Ch   (Sample_Ch),
        .Frame_Done  (Frame_Done),
        .Timeout_Err (Timeout_Err),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [CW-1:0] ch_sel;
        logic          adc_start;
        logic          sv;
        logic [DW-1:0] sd;
        logic [CW-1:0] sc;
        logic          fd;
        logic          te;
        logic          busy;
    } obs_t;

    typedef struct {
        int frames;
        int lat;
        int dead;
        int abort_t;
        int e_sv;
        int e_te;
        int e_fd;
        int e_fall;
    } row_t;

    obs_t          exp_a [MAXC];
    int            lat_a [MAXK];   // ADC latency per conversion, 0 = never answers
    logic [DW-1:0] dat_a [MAXK];
    logic [DW-1:0] last_sd = '0;
    logic [CW-1:0] last_sc = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_print = 0;

    function automatic obs_t sample();
        obs_t o;
        o.ch_sel    = Ch_Sel;
        o.adc_start = Adc_Start;
        o.sv        = Sample_Valid;
        o.sd        = Sample_Data;
        o.sc        = Sample_Ch;
        o.fd        = Frame_Done;
        o.te        = Timeout_Err;
        o.busy      = Busy;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %h expected %h", name, act, expv);
            end
        end
    endtask

    // Timeline model: cycle 1 is the first cycle after Start is sampled.
    task automatic build_model(input int f_cnt, input int abort_t,
                               output int end_t, output int lastf_start);
        int t, as_c, o, ch;
        logic [DW-1:0] sd;
        logic [CW-1:0] sc;
        for (int c = 0; c < MAXC; c++) exp_a[c] = '0;
        t = 1;
        lastf_start = 1;
        for (int k = 0; k < f_cnt * N; k++) begin
            ch = k % N;
            if (ch == 0) lastf_start = t;
            as_c = t + S;
            if (lat_a[k] != 0 && lat_a[k] <= T) begin
                o = as_c + lat_a[k] + 1;
                exp_a[o].sv = 1'b1;
                exp_a[o].sd = dat_a[k];
                exp_a[o].sc = CW'(ch);
            end else begin
                o = as_c + T + 1;
                exp_a[o].te = 1'b1;
            end
            exp_a[as_c].adc_start = 1'b1;
            for (int c = t; c <= o; c++) begin
                exp_a[c].ch_sel = CW'(ch);
                exp_a[c].busy   = 1'b1;
            end
            if (ch == N - 1) exp_a[o + 1].fd = 1'b1;
            t = o + 1;
        end
        end_t = t - 1;
        sd = last_sd;
        sc = last_sc;
        for (int c = 1; c <= end_t + 8; c++) begin
            if (c > end_t) exp_a[c].ch_sel = CW'(N - 1);
            if (exp_a[c].sv) begin
                sd = exp_a[c].sd;
                sc = exp_a[c].sc;
            end else begin
                exp_a[c].sd = sd;
                exp_a[c].sc = sc;
            end
        end
        if (abort_t > 0) begin
            sd = exp_a[abort_t].sd;
            sc = exp_a[abort_t].sc;
            for (int c = abort_t + 1; c <= abort_t + 8; c++) begin
                exp_a[c]    = '0;
                exp_a[c].sd = sd;
                exp_a[c].sc = sc;
            end
        end
    endtask

    // One frame sequence with an ADC model; rst_t > 0 stops the loop early.
    task automatic run(input int f_cnt, input int abort_t, input int rst_t,
                       output int n_sv, output int n_te, output int n_fd,
                       output int fall_t, output int first_as);
        int end_t, lfs, stop, lim, pending, pk, ck;
        build_model(f_cnt, abort_t, end_t, lfs);
        stop = (abort_t > 0) ? abort_t : end_t;
        lim  = (rst_t > 0) ? rst_t : stop + 6;
        n_sv = 0; n_te = 0; n_fd = 0; fall_t = -1; first_as = -1;
        pending = -1; pk = 0; ck = 0;
        @(negedge Clk);
        Start = 1'b1;
        Continuous = (f_cnt > 1);
        for (int t = 1; t <= lim; t++) begin
            @(negedge Clk);
            Start      = (t < stop) ? 1'($urandom % 2) : 1'b0;
            Continuous = (t < lfs);
            Abort      = (t == abort_t);
            Adc_Done   = (t == pending);
            Adc_Data   = (t == pending) ? dat_a[pk] : DW'($urandom);
            check($sformatf("cycle %0d", t), 64'(sample()), 64'(exp_a[t]));
            if (Adc_Start) begin
                if (first_as < 0) first_as = t;
                if (ck < MAXK && lat_a[ck] != 0) begin
                    pending = t + lat_a[ck];
                    pk = ck;
                end
                ck++;
            end
            if (Sample_Valid) n_sv++;
            if (Timeout_Err) n_te++;
            if (Frame_Done) n_fd++;
            if (fall_t < 0 && !Busy) fall_t = t;
        end
        Start = 1'b0; Abort = 1'b0; Adc_Done = 1'b0; Continuous = 1'b0;
        last_sd = exp_a[lim].sd;
        last_sc = exp_a[lim].sc;
    endtask

    row_t tab [8];

    initial begin
        int n_sv, n_te, n_fd, fall_t, first_as, f_cnt, dead;

        tab[0] = '{1,   3, -1,   0, 16, 0, 1,  209};   // basic frame
        tab[1] = '{1,   3,  5,   0, 15, 1, 1,  461};   // ch 5 silent
        tab[2] = '{3,   3, -1,   0, 48, 0, 3,  625};   // continuous x3
        tab[3] = '{1,   1, -1,   0, 16, 0, 1,  177};   // fastest ADC
        tab[4] = '{1, 255, -1,   0, 16, 0, 1, 4241};   // done on timeout cycle
        tab[5] = '{1,   2, 15,   0, 15, 1, 1,  446};   // last channel silent
        tab[6] = '{1,   3, -1, 103,  7, 0, 0,  104};   // abort in ch 7 wait with done
        tab[7] = '{1,   3, -1, 208, 16, 0, 0,  209};   // abort in last NEXT

        // Reset state
        repeat (3) @(negedge Clk);
        check("reset_hold", 64'(sample()), 64'(0));
        Reset = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            Adc_Done = 1'($urandom % 2);
            check("idle_no_start", 64'(sample()), 64'(0));
        end
        Adc_Done = 1'b0;

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < MAXK; k++) begin
                lat_a[k] = (k == tab[r].dead) ? 0 : tab[r].lat;
                dat_a[k] = DW'(32'h100 + k % N);
            end
            run(tab[r].frames, tab[r].abort_t, 0, n_sv, n_te, n_fd, fall_t, first_as);
            check($sformatf("row%0d samples", r), 64'(n_sv), 64'(tab[r].e_sv));
            check($sformatf("row%0d timeouts", r), 64'(n_te), 64'(tab[r].e_te));
            check($sformatf("row%0d frames", r), 64'(n_fd), 64'(tab[r].e_fd));
            check($sformatf("row%0d busy_fall", r), 64'(fall_t), 64'(tab[r].e_fall));
            check($sformatf("row%0d first_adc_start", r), 64'(first_as), 64'(S + 1));
        end

        // Reset between edges during ch 3 settling, then spurious ADC strobes
        for (int k = 0; k < MAXK; k++) begin
            lat_a[k] = 3;
            dat_a[k] = DW'(32'h100 + k % N);
        end
        run(1, 0, 43, n_sv, n_te, n_fd, fall_t, first_as);
        #2 Reset = 1'b1;
        #1 check("reset_async", 64'(sample()), 64'(0));
        @(negedge Clk);
        #2 Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            Adc_Done = 1'($urandom % 2);
            Adc_Data = DW'($urandom);
            check($sformatf("post_reset %0d", i), 64'(sample()), 64'(0));
        end
        Adc_Done = 1'b0;
        last_sd = '0;
        last_sc = '0;

        // Randomized frames: latencies, data, silent channel, Start noise
        for (int r = 0; r < 6; r++) begin
            f_cnt = 1 + int'($urandom % 2);
            dead  = ($urandom % 3 == 0) ? int'($urandom % (f_cnt * N)) : -1;
            for (int k = 0; k < MAXK; k++) begin
                lat_a[k] = (k == dead) ? 0 : 1 + int'($urandom % 6);
                dat_a[k] = DW'($urandom);
            end
            run(f_cnt, 0, 0, n_sv, n_te, n_fd, fall_t, first_as);
            check($sformatf("rand%0d frames", r), 64'(n_fd), 64'(f_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
